// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxsync_filt_pkg.sv
// Shared constants and helpers for the receive-side sync/filter cells.
// Holds the legal parameter limits and a constant-evaluable clog2.
package gf180mcu_fd_sc_mcu9t5v0__rxsync_filt_pkg;

    localparam int SYNC_MIN = 2;
    localparam int FILT_MAX = 256;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxsync_chain.sv
// Plain multi-flop synchroniser with a configurable async-reset value.
// Reused by any cell that brings a single bit into the local clock domain.
module gf180mcu_fd_sc_mcu9t5v0__rxsync_chain
    import gf180mcu_fd_sc_mcu9t5v0__rxsync_filt_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < SYNC_MIN) begin : g_bad_stages
            $error("rxsync_chain: STAGES must be at least %0d", SYNC_MIN);
        end
    endgenerate

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxsync_filt.sv
// Synchronises an asynchronous line, rejects short glitches with a
// persistence counter, and emits a clean level with rise/fall pulses.
module gf180mcu_fd_sc_mcu9t5v0__rxsync_filt
    import gf180mcu_fd_sc_mcu9t5v0__rxsync_filt_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CNT    = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic I,
    input  logic EN,
    output logic Z,
    output logic ZR,
    output logic ZF
);

    localparam int CNT_W = (clog2(FILT_CNT) > 1) ? clog2(FILT_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    generate
        if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
            $error("rxsync_filt: SYNC_STAGES must be at least %0d", SYNC_MIN);
        end
        if (FILT_CNT < 1 || FILT_CNT > FILT_MAX) begin : g_bad_filt
            $error("rxsync_filt: FILT_CNT must be in 1..%0d", FILT_MAX);
        end
    endgenerate

    logic           sync_s;
    logic [CNT_W-1:0] cnt;

    gf180mcu_fd_sc_mcu9t5v0__rxsync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_chain (
        .clk (CLK),
        .rst (RST),
        .d   (I),
        .q   (sync_s)
    );

    // Z only moves after FILT_CNT consecutive enabled mismatches; any agreement
    // clears the run, and EN=0 freezes the run where it stands.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            Z   <= RST_VAL;
            ZR  <= 1'b0;
            ZF  <= 1'b0;
        end else begin
            ZR <= 1'b0;
            ZF <= 1'b0;
            if (EN) begin
                if (sync_s == Z) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    Z   <= sync_s;
                    cnt <= '0;
                    ZR  <= sync_s;
                    ZF  <= ~sync_s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
